detector_botoes: RTL and testbench
==================================

// Module: detector_botoes
// PURPOSE
//  Front end of the 9-position board keypad. Synchronises the 9 raw button lines and debounces them.
//  Accepts only a single pressed button at a time.
//  Emits exactly one 1-cycle strobe per accepted press, carrying a clean one-hot vector that feeds
//  the one-hot-to-binary position converter downstream.
//  Sits between the board pins and the converter/game control unit.
// PARAMETERS
//  DEBOUNCE_CICLOS  default 4  consecutive stable cycles required to accept a press or a release (>=2)
// PORTS
//  clock          in   1  system clock, all flops on rising edge
//  reset          in   1  asynchronous, active-high; clears all state and outputs immediately
//  botoes_in      in   9  raw button lines, asynchronous to clock, 1 = pressed
//  habilita       in   1  1 = game accepts a move now; sampled on the accept edge
//  botoes_out     out  9  one-hot accepted button, valid only while pulso=1, else 0
//  pulso          out  1  1-cycle strobe: one valid press accepted
//  rejeitado      out  1  1-cycle strobe: debounced press accepted while habilita=0 (discarded)
//  db_estado      out  2  current FSM state code, for debug display
// BEHAVIOUR
//  Synchroniser: 2-flop chain per bit, botoes_in -> s1 -> s2. The FSM sees only s2.
//  Counter cnt: width clog2(DEBOUNCE_CICLOS)+1. Saturates; never wraps.
//  States (db_estado code):
//   OCIOSO=0  idle.
//    - s2==0: stay.
//    - s2 exactly one-hot: candidato<=s2, cnt<=0, go FILTRA.
//    - s2 with >=2 bits set: stay, no output (simultaneous presses ignored).
//   FILTRA=1  debouncing the press.
//    - s2!=candidato (release, glitch or 2nd button): go OCIOSO, no output.
//    - s2==candidato and cnt<N-1: cnt++.
//    - s2==candidato and cnt==N-1: go ESPERA.
//      On this edge: habilita=1 -> pulso<=1, botoes_out<=candidato;
//      habilita=0 -> rejeitado<=1, botoes_out stays 0.
//   ESPERA=2  waiting for full release.
//    - On entry cnt<=0.
//    - s2==0: cnt++; at cnt==N-1 go OCIOSO.
//    - any s2 bit set: cnt<=0 (release must be N stable all-zero cycles).
//  pulso, rejeitado, botoes_out are registered. Each is forced 0 on the edge after it was set
//  (exactly 1 cycle high).
//  Latency: input stable before edge E0 (first sampling edge into s1).
//   Outputs high in the cycle after edge E0+N+2; with N=4, edge E0+6.
//  One press held indefinitely -> exactly one strobe. Next strobe needs a full release first.
//  Second button added while in ESPERA: ignored. The release timer restarts; no strobe.
//  habilita is looked at only on the accept edge. Changes during FILTRA/ESPERA have no effect.
//  Reset (async, any time, incl. mid-FILTRA):
//   - s1, s2, candidato, cnt, botoes_out, pulso, rejeitado <= 0.
//   - State <= ESPERA, so a button held through reset is not accepted until released.
//   - db_estado=2 during reset.
// TESTING (N=4)
//  1. Reset with all buttons released, then botoes_in=9'h010 held 20 cycles
//     -> pulso=1 for 1 cycle, 6 edges after first sample;
//        botoes_out=9'h010 in that cycle, 0 otherwise; no further strobe while held.
//  2. botoes_in=9'h001 glitches for 2 cycles, then returns to 0
//     -> no pulso, no rejeitado; FSM returns to OCIOSO.
//  3. botoes_in=9'h003 held 20 cycles
//     -> no strobe.
//     Then 9'h002 only, after a full release
//     -> pulso with botoes_out=9'h002.
//  4. habilita=0, press 9'h100
//     -> rejeitado=1 for 1 cycle, pulso=0, botoes_out=0.
//     Release 5 cycles, set habilita=1, press 9'h100
//     -> pulso=1, botoes_out=9'h100.
//  5. Bouncy release (0/1 toggling, shorter than 4 cycles) then 9'h080 pressed cleanly
//     -> exactly one strobe for 9'h080, only after 4 clean zero cycles.
//  6. Assert reset mid-FILTRA while 9'h020 is held
//     -> outputs 0 at once, db_estado=2.
//     Release reset with button still held
//     -> no strobe until released 4 cycles and pressed again.

Source files
------------

// File: rtl/detector_botoes.sv
// Keypad front end: synchronises and debounces the 9 board buttons and emits one
// 1-cycle strobe with a clean one-hot vector for each accepted single press.
module detector_botoes #(
    parameter int DEBOUNCE_CICLOS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [8:0] botoes_in,
    input  logic       habilita,
    output logic [8:0] botoes_out,
    output logic       pulso,
    output logic       rejeitado,
    output logic [1:0] db_estado
);

    localparam int CW = $clog2(DEBOUNCE_CICLOS) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        FILTRA = 2'd1,
        ESPERA = 2'd2
    } estado_t;

    estado_t       r_estado;
    logic [8:0]    r_s1;
    logic [8:0]    r_s2;
    logic [8:0]    r_candidato;
    logic [CW-1:0] r_cnt;
    logic [8:0]    r_botoes_out;
    logic          r_pulso;
    logic          r_rejeitado;

    logic          w_um_quente;
    logic          w_vazio;

    assign w_vazio     = (r_s2 == 9'd0);
    assign w_um_quente = !w_vazio && ((r_s2 & (r_s2 - 9'd1)) == 9'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1 <= 9'd0;
            r_s2 <= 9'd0;
        end else begin
            r_s1 <= botoes_in;
            r_s2 <= r_s1;
        end
    end

    // Reset lands in ESPERA so a button held through reset must be released first.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado     <= ESPERA;
            r_candidato  <= 9'd0;
            r_cnt        <= '0;
            r_botoes_out <= 9'd0;
            r_pulso      <= 1'b0;
            r_rejeitado  <= 1'b0;
        end else begin
            r_botoes_out <= 9'd0;
            r_pulso      <= 1'b0;
            r_rejeitado  <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (w_um_quente) begin
                        r_candidato <= r_s2;
                        r_cnt       <= '0;
                        r_estado    <= FILTRA;
                    end
                end
                FILTRA: begin
                    if (r_s2 != r_candidato) begin
                        r_estado <= OCIOSO;
                    end else if (r_cnt < CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt    <= '0;
                        r_estado <= ESPERA;
                        if (habilita) begin
                            r_pulso      <= 1'b1;
                            r_botoes_out <= r_candidato;
                        end else begin
                            r_rejeitado <= 1'b1;
                        end
                    end
                end
                ESPERA: begin
                    if (!w_vazio) begin
                        r_cnt <= '0;
                    end else if (r_cnt >= CNT_MAX) begin
                        r_estado <= OCIOSO;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_cnt    <= '0;
                    r_estado <= ESPERA;
                end
            endcase
        end
    end

    assign botoes_out = r_botoes_out;
    assign pulso      = r_pulso;
    assign rejeitado  = r_rejeitado;
    assign db_estado  = r_estado;

endmodule

// File: tb/tb_detector_botoes.sv
// Directed bench for detector_botoes (N=4): press, glitch, double press, habilita,
// bouncy release and reset mid-debounce, with hand-computed strobe timing.
module tb_detector_botoes;

    logic       clock;
    logic       reset;
    logic [8:0] botoes_in;
    logic       habilita;
    logic [8:0] botoes_out;
    logic       pulso;
    logic       rejeitado;
    logic [1:0] db_estado;

    int n_checks;
    int n_pass;

    // per-window observations collected by run()
    int         n_pulsos;
    int         n_rej;
    int         primeiro;
    logic [8:0] out_no_pulso;
    int         out_sem_pulso;

    detector_botoes #(.DEBOUNCE_CICLOS(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .botoes_in  (botoes_in),
        .habilita   (habilita),
        .botoes_out (botoes_out),
        .pulso      (pulso),
        .rejeitado  (rejeitado),
        .db_estado  (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Runs n cycles; cycle k is sampled on the falling edge after rising edge k.
    task automatic run(input int n);
        n_pulsos      = 0;
        n_rej         = 0;
        primeiro      = -1;
        out_no_pulso  = 9'd0;
        out_sem_pulso = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (pulso) begin
                n_pulsos++;
                if (primeiro < 0) primeiro = i;
                out_no_pulso = botoes_out;
            end else if (botoes_out != 9'd0) begin
                out_sem_pulso++;
            end
            if (rejeitado) n_rej++;
        end
    endtask

    task automatic press_accept(input string tag, input logic [8:0] b);
        botoes_in = b;
        run(20);
        check({tag, "_pulsos"}, n_pulsos, 1);
        check({tag, "_latencia"}, primeiro, 6);
        check({tag, "_out"}, out_no_pulso, b);
        check({tag, "_out_fora"}, out_sem_pulso, 0);
        check({tag, "_rej"}, n_rej, 0);
    endtask

    task automatic release_idle(input string tag);
        botoes_in = 9'd0;
        run(10);
        check({tag, "_sem_pulso"}, n_pulsos + n_rej, 0);
        check({tag, "_ocioso"}, db_estado, 0);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        botoes_in = 9'd0;
        habilita  = 1'b1;
        #1;
        check("reset_estado", db_estado, 2);
        check("reset_pulso", pulso, 0);
        check("reset_out", botoes_out, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        run(8);
        check("pos_reset_ocioso", db_estado, 0);

        // 1: clean press held 20 cycles
        press_accept("t1", 9'h010);
        release_idle("t1_rel");

        // 2: two-cycle glitch
        botoes_in = 9'h001;
        run(2);
        botoes_in = 9'd0;
        run(10);
        check("t2_pulso", n_pulsos, 0);
        check("t2_rej", n_rej, 0);
        check("t2_ocioso", db_estado, 0);

        // 3: two buttons together are ignored
        botoes_in = 9'h003;
        run(20);
        check("t3_duplo_pulso", n_pulsos + n_rej, 0);
        check("t3_duplo_ocioso", db_estado, 0);
        botoes_in = 9'd0;
        run(6);
        press_accept("t3", 9'h002);
        release_idle("t3_rel");

        // 4: press while habilita=0 is rejected
        habilita  = 1'b0;
        botoes_in = 9'h100;
        run(20);
        check("t4_rej", n_rej, 1);
        check("t4_pulso", n_pulsos, 0);
        check("t4_out", out_sem_pulso, 0);
        check("t4_espera", db_estado, 2);
        botoes_in = 9'd0;
        run(5);
        habilita = 1'b1;
        press_accept("t4", 9'h100);
        release_idle("t4_rel");

        // 5: bouncy release keeps ESPERA, then clean press of 0x080
        press_accept("t5_a", 9'h040);
        botoes_in = 9'd0;   run(3);
        botoes_in = 9'h040; run(1);
        botoes_in = 9'd0;   run(2);
        botoes_in = 9'h040; run(2);
        botoes_in = 9'd0;   run(3);
        botoes_in = 9'h040; run(1);
        check("t5_bounce_espera", db_estado, 2);
        botoes_in = 9'd0;
        run(6);
        check("t5_libera_ocioso", db_estado, 0);
        press_accept("t5", 9'h080);
        release_idle("t5_rel");

        // 6: reset mid-FILTRA with the button held through it
        botoes_in = 9'h020;
        run(4);
        check("t6_filtra", db_estado, 1);
        reset = 1'b1;
        #1;
        check("t6_reset_estado", db_estado, 2);
        check("t6_reset_pulso", pulso, 0);
        check("t6_reset_out", botoes_out, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        run(20);
        check("t6_segurado", n_pulsos + n_rej, 0);
        check("t6_segurado_espera", db_estado, 2);
        release_idle("t6_rel");
        press_accept("t6", 9'h020);
        release_idle("t6_fim");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
